// File: rtl/fetch_ctrl.sv
// Instruction fetch/sequencing controller: owns pc, ir and the N/Z/C/V flags,
// fetches over a req/ack port and issues one datapath-enable cycle per instruction.
module fetch_ctrl #(
    parameter int                   REG_WIDTH = 16,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [REG_WIDTH-1:0] imem_addr,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [REG_WIDTH-1:0] imem_rdata,
    input  logic                 dmem_wait,
    output logic [REG_WIDTH-1:0] ins,
    output logic [REG_WIDTH-1:0] pcin,
    output logic                 dpen,
    input  logic                 flagn,
    input  logic                 flagz,
    input  logic                 flagc,
    input  logic                 flagv,
    output logic                 flagcin,
    output logic                 halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0] ir_q, ir_d;
    logic                 n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic [REG_WIDTH-1:0] pc_inc;
    logic [REG_WIDTH-1:0] jmp_target;
    logic [3:0]           opcode;
    logic [2:0]           cond;
    logic                 inv;
    logic                 base;
    logic                 taken;

    // Opcode lives in the top nibble of the instruction word.
    assign opcode     = ir_q[REG_WIDTH-1 -: 4];
    assign cond       = ir_q[11:9];
    assign inv        = ir_q[8];
    assign pc_inc     = pc_q + REG_WIDTH'(1);
    assign jmp_target = pc_q + {{(REG_WIDTH-8){ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        base = 1'b1;
        case (cond)
            3'b000: base = 1'b1;
            3'b001: base = z_q;
            3'b010: base = c_q;
            3'b011: base = n_q;
            3'b100: base = (n_q == v_q);
            3'b101: base = !z_q && (n_q == v_q);
            3'b110: base = c_q && !z_q;
            default: base = 1'b1;
        endcase
        taken = base ^ inv;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        imem_req = 1'b0;
        dpen     = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // A pending data-memory access freezes everything, including dpen.
                if (!dmem_wait) begin
                    dpen    = 1'b1;
                    state_d = S_FETCH;
                    case (opcode)
                        4'hC: pc_d = taken ? jmp_target : pc_inc;
                        4'hD: pc_d = jmp_target;
                        4'hE: pc_d = pc_inc;
                        4'hF: state_d = S_HALT;
                        default: begin
                            pc_d = pc_inc;
                            n_d  = flagn;
                            z_d  = flagz;
                            c_d  = flagc;
                            v_d  = flagv;
                        end
                    endcase
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign imem_addr = pc_q;
    assign ins       = ir_q;
    assign pcin      = pc_inc;
    assign flagcin   = c_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of instructions walked through fetch and
// execute, plus hand sequences for reset abort and the halt state.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        dmem_wait = 1'b0;
    logic [15:0] ins;
    logic [15:0] pcin;
    logic        dpen;
    logic        flagn = 1'b0, flagz = 1'b0, flagc = 1'b0, flagv = 1'b0;
    logic        flagcin;
    logic        halted;

    always #5 clk = ~clk;

    fetch_ctrl #(.REG_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_wait (dmem_wait),
        .ins       (ins),
        .pcin      (pcin),
        .dpen      (dpen),
        .flagn     (flagn),
        .flagz     (flagz),
        .flagc     (flagc),
        .flagv     (flagv),
        .flagcin   (flagcin),
        .halted    (halted)
    );

    typedef struct {
        logic [15:0] instr;
        int          ack_dly;
        int          dwait;
        logic [3:0]  fl;
        logic [15:0] addr;
        logic        cin;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] exp_pcin;
        exp_pcin = v.addr + 16'd1;
        for (int i = 0; i <= v.ack_dly; i++) begin
            @(negedge clk);
            dmem_wait  = 1'b0;
            imem_ack   = (i == v.ack_dly);
            imem_rdata = (i == v.ack_dly) ? v.instr : ~v.instr;
            #1;
            check($sformatf("v%0d fetch imem_req", idx), {15'd0, imem_req}, 16'd1);
            check($sformatf("v%0d fetch imem_addr", idx), imem_addr, v.addr);
            check($sformatf("v%0d fetch dpen", idx), {15'd0, dpen}, 16'd0);
        end
        for (int w = 0; w <= v.dwait; w++) begin
            @(negedge clk);
            imem_ack   = 1'b1;
            imem_rdata = 16'hDEAD;
            dmem_wait  = (w < v.dwait);
            {flagn, flagz, flagc, flagv} = v.fl;
            #1;
            check($sformatf("v%0d exec%0d dpen", idx, w), {15'd0, dpen}, (w == v.dwait) ? 16'd1 : 16'd0);
            check($sformatf("v%0d exec ins", idx), ins, v.instr);
            check($sformatf("v%0d exec pcin", idx), pcin, exp_pcin);
            check($sformatf("v%0d exec flagcin", idx), {15'd0, flagcin}, {15'd0, v.cin});
            check($sformatf("v%0d exec imem_req", idx), {15'd0, imem_req}, 16'd0);
            check($sformatf("v%0d exec imem_addr", idx), imem_addr, v.addr);
        end
    endtask

    initial begin
        //         instr    ack dw  nzcv     fetch addr cin
        vecs[0]  = '{16'h1000, 0, 0, 4'b0000, 16'h0000, 1'b0};
        vecs[1]  = '{16'h2000, 0, 0, 4'b0010, 16'h0001, 1'b0};
        vecs[2]  = '{16'h1234, 3, 0, 4'b0100, 16'h0002, 1'b1};
        vecs[3]  = '{16'hC00D, 0, 0, 4'b0000, 16'h0003, 1'b0};
        vecs[4]  = '{16'h3000, 0, 2, 4'b0110, 16'h0010, 1'b0};
        vecs[5]  = '{16'hC200, 0, 0, 4'b0000, 16'h0011, 1'b1};
        vecs[6]  = '{16'hC2FE, 0, 0, 4'b0000, 16'h0011, 1'b1};
        vecs[7]  = '{16'hC300, 0, 0, 4'b0000, 16'h000F, 1'b1};
        vecs[8]  = '{16'hC010, 0, 0, 4'b0000, 16'h0010, 1'b1};
        vecs[9]  = '{16'hD005, 0, 0, 4'b0000, 16'h0020, 1'b1};
        vecs[10] = '{16'hCC05, 0, 0, 4'b0000, 16'h0025, 1'b1};
        vecs[11] = '{16'hC803, 0, 0, 4'b0000, 16'h0026, 1'b1};
        vecs[12] = '{16'hE123, 1, 1, 4'b0000, 16'h0029, 1'b1};
        vecs[13] = '{16'hC080, 0, 0, 4'b0000, 16'h002A, 1'b1};
        vecs[14] = '{16'hC055, 0, 0, 4'b0000, 16'hFFAA, 1'b1};
        vecs[15] = '{16'h4000, 0, 0, 4'b1001, 16'hFFFF, 1'b1};
        vecs[16] = '{16'hCA04, 0, 0, 4'b0000, 16'h0000, 1'b0};
        vecs[17] = '{16'hC702, 0, 0, 4'b0000, 16'h0004, 1'b0};
        vecs[18] = '{16'hF000, 0, 0, 4'b0000, 16'h0005, 1'b0};

        // Reset held across a fetch with ack asserted: nothing may load.
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        repeat (2) @(negedge clk);
        #1;
        check("reset imem_req", {15'd0, imem_req}, 16'd1);
        check("reset imem_addr", imem_addr, 16'h0000);
        check("reset dpen", {15'd0, dpen}, 16'd0);
        check("reset halted", {15'd0, halted}, 16'd0);
        check("reset pcin", pcin, 16'h0001);
        check("reset ins", ins, 16'h0000);
        check("reset flagcin", {15'd0, flagcin}, 16'd0);

        // Fetch an ALU op, stall it with carry pending, then abort with async reset.
        @(negedge clk);
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1000;
        @(negedge clk);
        imem_ack  = 1'b0;
        dmem_wait = 1'b1;
        flagc     = 1'b1;
        #1;
        check("abort stall dpen", {15'd0, dpen}, 16'd0);
        check("abort stall ins", ins, 16'h1000);
        #1;
        rst = 1'b1;
        #1;
        check("abort async ins", ins, 16'h0000);
        check("abort async imem_req", {15'd0, imem_req}, 16'd1);
        check("abort async dpen", {15'd0, dpen}, 16'd0);
        @(negedge clk);
        #1;
        check("abort flagcin", {15'd0, flagcin}, 16'd0);
        check("abort imem_addr", imem_addr, 16'h0000);
        rst       = 1'b0;
        dmem_wait = 1'b0;
        flagc     = 1'b0;
        imem_ack  = 1'b0;

        for (int k = 0; k < NVEC; k++) run_vec(k, vecs[k]);

        // After HALT: parked forever, ack ignored, pc not advanced.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            imem_ack   = 1'b1;
            imem_rdata = 16'h1111;
            dmem_wait  = 1'b0;
            #1;
            check($sformatf("halt%0d halted", c), {15'd0, halted}, 16'd1);
            check($sformatf("halt%0d imem_req", c), {15'd0, imem_req}, 16'd0);
            check($sformatf("halt%0d dpen", c), {15'd0, dpen}, 16'd0);
            check($sformatf("halt%0d imem_addr", c), imem_addr, 16'h0005);
            check($sformatf("halt%0d ins", c), ins, 16'hF000);
        end

        rst = 1'b1;
        #1;
        check("halt reset halted", {15'd0, halted}, 16'd0);
        check("halt reset imem_addr", imem_addr, 16'h0000);
        check("halt reset imem_req", {15'd0, imem_req}, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
